csr_file_m: RTL
===============

# csr_file_m

Machine-mode CSR file for the core: executes CSRRW/CSRRS/CSRRC (register and immediate forms), sequences trap entry and MRET, holds the interrupt-enable/pending state, and optionally provides mcycle/minstret. It generalises the existing per-register CSR unit with parametrised counter width, a selectable vectored-trap mode, real mtval and mip/mie state, and illegal-access reporting. It sits beside the execute stage; the pipeline consumes `trap_vector_o`, `mepc_o` and `irq_pending_o` for redirects.

## Interface
- HART_ID, 0: value returned by mhartid (0xF14).
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec.
- VECTORED, 1: 1 allows mtvec.MODE=01 (vectored); 0 hardwires MODE to 00.
- COUNTER_W, 64: mcycle/minstret width, 32 or 64.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- csr_en_i  in  1  CSR instruction valid this cycle.
- csr_op_i  in  2  01 RW, 10 RS, 11 RC; 00 treated as no access.
- csr_src_sel_i  in  1  0 = csr_rs1_i, 1 = zero-extended csr_uimm_i.
- csr_uimm_i  in  5  rs1 index / uimm field.
- csr_rs1_i  in  32  rs1 value.
- csr_addr_i  in  12  CSR address.
- csr_rdata_o  out  32  old CSR value (combinational).
- csr_illegal_o  out  1  illegal access (combinational).
- trap_i  in  1  take trap this cycle.
- trap_irq_i  in  1  trap is an interrupt.
- trap_cause_i  in  5  exception/interrupt code.
- trap_pc_i  in  32  faulting/interrupted PC.
- trap_tval_i  in  32  mtval value.
- mret_i  in  1  execute MRET.
- instret_i  in  1  one instruction retired.
- irq_ext_i, irq_timer_i  in  1 each  raw interrupt lines.
- trap_vector_o  out  32  target PC for current trap.
- mepc_o  out  32  mepc.
- irq_pending_o  out  1  mstatus.MIE & |(mie & mip).

## Operation
- Source = sel ? {27'b0,uimm} : rs1. RW: new = src. RS: old | src. RC: old & ~src.
- Write intent = RW, or RS/RC with csr_uimm_i != 0. RS/RC with uimm 0 read only.
- Implemented: mstatus(300), misa(301, RO, RV32I), mie(304), mtvec(305), mstatush(310, zero), mscratch(340), mepc(341), mcause(342), mtval(343), mip(344), mhartid(F14, RO); counters per Configuration.
- mstatus: MIE bit3, MPIE bit7 writable; MPP[12:11] reads 11; rest zero. mie: MTIE bit7, MEIE bit11. mip: MTIP/MEIP read-only, from registered irq inputs; writes ignored silently.
- mepc[1:0] and mtvec[1] always read 0; mtvec[0] reads 0 when VECTORED=0.
- Illegal when csr_en_i and (address unimplemented, or write intent to addr[11:10]==11): csr_rdata_o=0, no state change.
- Trap entry: mepc<=trap_pc&~3, mcause<={trap_irq,26'b0,cause}, mtval<=tval, MPIE<=MIE, MIE<=0.
- trap_vector_o = base, or base + 4*cause when MODE=01 and trap_irq_i.
- MRET: MIE<=MPIE, MPIE<=1.
- Priority per edge: trap > mret > CSR write. Lower-priority updates are dropped.

## Timing
- Reset: all outputs 0 except trap_vector_o = MTVEC_RESET base, csr_rdata_o per address; MIE=MPIE=0, mie=0, mip=0, counters 0.
- CSR writes visible on next cycle's read; same-cycle read returns old value.
- irq inputs: one flop to mip; irq_pending_o rises 1 cycle after input.
- Counter: increment every cycle (mcycle) / when instret_i (minstret); carry low->high on wrap of 0xFFFF_FFFF. A write to either half in a cycle replaces that half and suppresses that counter's increment that cycle.
- Reset mid-instruction: all state returns to reset values immediately.

## Configuration
- CSR_COUNTERS_EN defined: mcycle(B00/B80), minstret(B02/B82) RW, cycle/instret(C00/C02/C80/C82) RO. COUNTER_W=32: high halves read 0, writes ignored.
- Undefined: no counter hardware; those addresses illegal.

## Structure
- Package csr_pkg: CSR address constants, op codes, mstatus/mie/mip bit positions, cause codes.
- Sub-module csr_counter (width, inc enable, low/high write ports), instanced per counter.

## Test plan
- Reset, read mtvec with MTVEC_RESET=0x100 -> 0x100; mstatus -> 0x1800.
- CSRRS mscratch rs1=0xF0 on 0x0F, then CSRRC uimm=0x3 -> reads 0xFF then 0xFC.
- MIE=1, trap pc=0x2002 cause 2 -> mepc 0x2000, mcause 2, MIE 0, MPIE 1; MRET -> MIE 1.
- mtvec=0x401, irq_timer, mie.MTIE, MIE -> irq_pending_o after 1 cycle, trap_vector_o 0x41C.
- Write mcycle low 0xFFFF_FFFF -> next cycle 0xFFFF_FFFF, then mcycleh increments by 1.
- CSRRW to F14, and to 0x7C0 -> csr_illegal_o=1, rdata 0, no state change.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op codes, bit positions, cause codes.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSTATUSH  = 12'h310;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    // MXL=01 (RV32) with only the I extension bit set.
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    localparam logic [4:0] CAUSE_ILLEGAL_INSTR = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT    = 5'd3;
    localparam logic [4:0] CAUSE_ECALL_M       = 5'd11;
    localparam logic [4:0] CAUSE_IRQ_M_TIMER   = 5'd7;
    localparam logic [4:0] CAUSE_IRQ_M_EXT     = 5'd11;

endpackage

// File: rtl/csr_file_m_counter.sv
// Split 32/64-bit performance counter with independent low/high write ports.
module csr_counter #(
    parameter int W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        step;

    // Any software write to the counter wins over that cycle's increment.
    assign step = inc && !wr_lo && !wr_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= 32'd0;
            hi_q <= 32'd0;
        end else begin
            if (wr_lo) begin
                lo_q <= wdata;
            end else if (step) begin
                lo_q <= lo_q + 32'd1;
            end
            if (W == 64) begin
                if (wr_hi) begin
                    hi_q <= wdata;
                end else if (step && (lo_q == 32'hFFFF_FFFF)) begin
                    hi_q <= hi_q + 32'd1;
                end
            end
        end
    end

    assign lo = lo_q;
    assign hi = (W == 64) ? hi_q : 32'd0;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSRRW/RS/RC, trap entry, MRET, interrupt enable/pending state.
// Optional mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_file_m
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED    = 1'b1,
    parameter int          COUNTER_W   = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        csr_en_i,
    input  logic [1:0]  csr_op_i,
    input  logic        csr_src_sel_i,
    input  logic [4:0]  csr_uimm_i,
    input  logic [31:0] csr_rs1_i,
    input  logic [11:0] csr_addr_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        trap_i,
    input  logic        trap_irq_i,
    input  logic [4:0]  trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_i,
    input  logic        instret_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    output logic [31:0] trap_vector_o,
    output logic [31:0] mepc_o,
    output logic        irq_pending_o
);

    logic        mstatus_mie_q, mstatus_mpie_q;
    logic        mie_mtie_q, mie_meie_q;
    logic        mip_mtip_q, mip_meip_q;
    logic [31:2] mtvec_base_q;
    logic        mtvec_mode_q;
    logic [31:2] mepc_q;
    logic [31:0] mscratch_q, mcause_q, mtval_q;

    csr_op_e     op;
    logic        access, write_intent, implemented, do_write;
    logic [31:0] src, rdata_raw, wdata;

    assign op           = csr_op_e'(csr_op_i);
    assign access       = csr_en_i && (op != OP_NONE);
    assign src          = csr_src_sel_i ? {27'd0, csr_uimm_i} : csr_rs1_i;
    assign write_intent = (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && (csr_uimm_i != 5'd0));

`ifdef CSR_COUNTERS_EN
    logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;

    csr_counter #(.W(COUNTER_W)) u_mcycle (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (1'b1),
        .wr_lo (do_write && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi (do_write && (csr_addr_i == CSR_MCYCLEH)),
        .wdata (wdata),
        .lo    (mcycle_lo),
        .hi    (mcycle_hi)
    );

    csr_counter #(.W(COUNTER_W)) u_minstret (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (instret_i),
        .wr_lo (do_write && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi (do_write && (csr_addr_i == CSR_MINSTRETH)),
        .wdata (wdata),
        .lo    (minstret_lo),
        .hi    (minstret_hi)
    );
`else
    logic unused_instret;
    assign unused_instret = instret_i;
`endif

    always_comb begin
        rdata_raw   = 32'd0;
        implemented = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                rdata_raw[12:11]          = 2'b11;
                rdata_raw[MSTATUS_MIE]    = mstatus_mie_q;
                rdata_raw[MSTATUS_MPIE]   = mstatus_mpie_q;
            end
            CSR_MISA:     rdata_raw = MISA_VALUE;
            CSR_MIE: begin
                rdata_raw[MIE_MTIE] = mie_mtie_q;
                rdata_raw[MIE_MEIE] = mie_meie_q;
            end
            CSR_MTVEC:    rdata_raw = {mtvec_base_q, 1'b0, mtvec_mode_q};
            CSR_MSTATUSH: rdata_raw = 32'd0;
            CSR_MSCRATCH: rdata_raw = mscratch_q;
            CSR_MEPC:     rdata_raw = {mepc_q, 2'b00};
            CSR_MCAUSE:   rdata_raw = mcause_q;
            CSR_MTVAL:    rdata_raw = mtval_q;
            CSR_MIP: begin
                rdata_raw[MIP_MTIP] = mip_mtip_q;
                rdata_raw[MIP_MEIP] = mip_meip_q;
            end
            CSR_MHARTID:  rdata_raw = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE, CSR_CYCLE:       rdata_raw = mcycle_lo;
            CSR_MCYCLEH, CSR_CYCLEH:     rdata_raw = mcycle_hi;
            CSR_MINSTRET, CSR_INSTRET:   rdata_raw = minstret_lo;
            CSR_MINSTRETH, CSR_INSTRETH: rdata_raw = minstret_hi;
`endif
            default:      implemented = 1'b0;
        endcase
    end

    // Read-only space is addr[11:10]==11; writing there is illegal, reading is fine.
    assign csr_illegal_o = access && (!implemented || (write_intent && (csr_addr_i[11:10] == 2'b11)));
    assign csr_rdata_o   = csr_illegal_o ? 32'd0 : rdata_raw;

    always_comb begin
        wdata = rdata_raw;
        case (op)
            OP_RW:   wdata = src;
            OP_RS:   wdata = rdata_raw | src;
            OP_RC:   wdata = rdata_raw & ~src;
            default: wdata = rdata_raw;
        endcase
    end

    // Trap and MRET on the same edge take the register file; the CSR write is dropped.
    assign do_write = access && write_intent && !csr_illegal_o && !trap_i && !mret_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_base_q   <= MTVEC_RESET[31:2];
            mtvec_mode_q   <= VECTORED & MTVEC_RESET[0];
            mepc_q         <= 30'd0;
            mscratch_q     <= 32'd0;
            mcause_q       <= 32'd0;
            mtval_q        <= 32'd0;
        end else if (trap_i) begin
            mepc_q         <= trap_pc_i[31:2];
            mcause_q       <= {trap_irq_i, 26'd0, trap_cause_i};
            mtval_q        <= trap_tval_i;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (mret_i) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (do_write) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_q  <= wdata[MSTATUS_MIE];
                    mstatus_mpie_q <= wdata[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    mie_mtie_q <= wdata[MIE_MTIE];
                    mie_meie_q <= wdata[MIE_MEIE];
                end
                CSR_MTVEC: begin
                    mtvec_base_q <= wdata[31:2];
                    mtvec_mode_q <= VECTORED & wdata[0];
                end
                CSR_MSCRATCH: mscratch_q <= wdata;
                CSR_MEPC:     mepc_q     <= wdata[31:2];
                CSR_MCAUSE:   mcause_q   <= wdata;
                CSR_MTVAL:    mtval_q    <= wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mip_mtip_q <= 1'b0;
            mip_meip_q <= 1'b0;
        end else begin
            mip_mtip_q <= irq_timer_i;
            mip_meip_q <= irq_ext_i;
        end
    end

    assign trap_vector_o = (mtvec_mode_q && trap_irq_i)
                         ? {mtvec_base_q, 2'b00} + {25'd0, trap_cause_i, 2'b00}
                         : {mtvec_base_q, 2'b00};
    assign mepc_o        = {mepc_q, 2'b00};
    assign irq_pending_o = mstatus_mie_q && ((mie_mtie_q && mip_mtip_q) || (mie_meie_q && mip_meip_q));

endmodule
